// File: rtl/tinker_regfile_if.sv
// Register-file access bus: three read addresses with a shared read strobe,
// one write port, and the registered read results coming back.
interface tinker_regfile_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [ADDR_W-1:0] rc_addr;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [DATA_W-1:0] rc_data;
  logic              rd_valid;

  modport master (
    output rd_en, ra_addr, rb_addr, rc_addr, we, wa, wd,
    input  ra_data, rb_data, rc_data, rd_valid
  );

  modport slave (
    input  rd_en, ra_addr, rb_addr, rc_addr, we, wa, wd,
    output ra_data, rb_data, rc_data, rd_valid
  );
endinterface

// File: rtl/tinker_regfile.sv
// Tinker 32 x 64-bit register file: three registered read ports with
// same-cycle write bypass, one write port, r31 resets to the stack top.
module tinker_regfile #(
  parameter int          DATA_W     = 64,
  parameter int          ADDR_W     = 5,
  parameter int unsigned STACK_INIT = 524288
) (
  input logic            clk,
  input logic            rst_n,
  tinker_regfile_if.slave bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] ra_p1;
  logic [DATA_W-1:0] rb_p1;
  logic [DATA_W-1:0] rc_p1;
  logic              vld_p1;

  // A port reading the register written on this edge sees the new value.
  function automatic logic [DATA_W-1:0] bypass(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    return (wr && (waddr == addr)) ? wdata : stored;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == NREG - 1) ? DATA_W'(STACK_INIT) : '0;
      end
    end else if (bus.we) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // p0 -> p1: address capture into the output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_p1  <= '0;
      rb_p1  <= '0;
      rc_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.rd_en;
      if (bus.rd_en) begin
        ra_p1 <= bypass(bus.ra_addr, regs[bus.ra_addr], bus.we, bus.wa, bus.wd);
        rb_p1 <= bypass(bus.rb_addr, regs[bus.rb_addr], bus.we, bus.wa, bus.wd);
        rc_p1 <= bypass(bus.rc_addr, regs[bus.rc_addr], bus.we, bus.wa, bus.wd);
      end
    end
  end

  assign bus.ra_data  = ra_p1;
  assign bus.rb_data  = rb_p1;
  assign bus.rc_data  = rc_p1;
  assign bus.rd_valid = vld_p1;

endmodule

// File: tb/tb_tinker_regfile.sv
// Self-checking bench for tinker_regfile: directed scenarios plus a randomized
// run against an array-based reference model of the register file.
module tb_tinker_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tinker_regfile_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  tinker_regfile #(.DATA_W(64), .ADDR_W(5), .STACK_INIT(524288)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [63:0] mregs [32];
  logic [63:0] ma, mb, mc;
  logic        mv;

  // Operand mux fed by the read ports
  logic [1:0]  ctrl;
  logic [63:0] mux_out;
  always_comb begin
    mux_out = '0;
    case (ctrl)
      2'd0: mux_out = bus.ra_data;
      2'd1: mux_out = bus.rb_data;
      2'd2: mux_out = bus.rc_data;
      default: mux_out = '0;
    endcase
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    mregs[31] = 64'd524288;
    ma = '0; mb = '0; mc = '0; mv = 1'b0;
  endtask

  task automatic drive(input logic ren, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input logic w, input logic [4:0] wadr,
                       input logic [63:0] wdat);
    bus.rd_en = ren; bus.ra_addr = a; bus.rb_addr = b; bus.rc_addr = c;
    bus.we = w; bus.wa = wadr; bus.wd = wdat;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // Advance one clock; the model applies the same edge from the register-file rules.
  task automatic tick();
    if (bus.rd_en) begin
      ma = (bus.we && bus.wa == bus.ra_addr) ? bus.wd : mregs[bus.ra_addr];
      mb = (bus.we && bus.wa == bus.rb_addr) ? bus.wd : mregs[bus.rb_addr];
      mc = (bus.we && bus.wa == bus.rc_addr) ? bus.wd : mregs[bus.rc_addr];
    end
    mv = bus.rd_en;
    if (bus.we) mregs[bus.wa] = bus.wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 5'd0, 5'd17, 5'd31, 1'b0, 5'd0, 64'd0);
    tick();
    vectors++; if (bus.ra_data !== 64'd0) begin miscompares++; $display("FAIL reset_ra got %0d want 0", bus.ra_data); end
    vectors++; if (bus.rb_data !== 64'd0) begin miscompares++; $display("FAIL reset_rb got %0d want 0", bus.rb_data); end
    vectors++; if (bus.rc_data !== 64'd524288) begin miscompares++; $display("FAIL reset_rc got %0d want 524288", bus.rc_data); end
    vectors++; if (bus.rd_valid !== 1'b1) begin miscompares++; $display("FAIL reset_valid got %b want 1", bus.rd_valid); end
    idle();
    tick();
    vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL valid_drop got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_write_read();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 64'hDEADBEEFCAFEF00D);
    tick();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0);
    tick();
    vectors++; if (bus.ra_data !== 64'hDEADBEEFCAFEF00D) begin miscompares++; $display("FAIL wr_r5 got %h want deadbeefcafef00d", bus.ra_data); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 64'd7);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd31, 64'h0123456789ABCDEF);
    tick();
    drive(1'b1, 5'd0, 5'd31, 5'd5, 1'b0, 5'd0, 64'd0);
    tick();
    vectors++; if (bus.ra_data !== 64'd7) begin miscompares++; $display("FAIL wr_r0 got %0d want 7", bus.ra_data); end
    vectors++; if (bus.rb_data !== 64'h0123456789ABCDEF) begin miscompares++; $display("FAIL wr_r31 got %h want 0123456789abcdef", bus.rb_data); end
    vectors++; if (bus.rc_data !== 64'hDEADBEEFCAFEF00D) begin miscompares++; $display("FAIL wr_r5_again got %h want deadbeefcafef00d", bus.rc_data); end
  endtask

  task automatic test_bypass();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd10, 64'h1111);
    tick();
    drive(1'b1, 5'd9, 5'd9, 5'd10, 1'b1, 5'd9, 64'd123);
    tick();
    vectors++; if (bus.ra_data !== 64'd123) begin miscompares++; $display("FAIL byp_ra got %0d want 123", bus.ra_data); end
    vectors++; if (bus.rb_data !== 64'd123) begin miscompares++; $display("FAIL byp_rb got %0d want 123", bus.rb_data); end
    vectors++; if (bus.rc_data !== 64'h1111) begin miscompares++; $display("FAIL byp_rc got %h want 1111", bus.rc_data); end
    drive(1'b1, 5'd10, 5'd9, 5'd10, 1'b0, 5'd0, 64'd0);
    tick();
    vectors++; if (bus.rb_data !== 64'd123) begin miscompares++; $display("FAIL byp_stored got %0d want 123", bus.rb_data); end
  endtask

  task automatic test_hold();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 64'd42);
    tick();
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0);
    tick();
    vectors++; if (bus.ra_data !== 64'd42) begin miscompares++; $display("FAIL hold_pre got %0d want 42", bus.ra_data); end
    drive(1'b0, 5'd3, 5'd0, 5'd0, 1'b1, 5'd3, 64'd99);
    tick();
    vectors++; if (bus.ra_data !== 64'd42) begin miscompares++; $display("FAIL hold_data got %0d want 42", bus.ra_data); end
    vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL hold_valid got %b want 0", bus.rd_valid); end
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 64'd0);
    tick();
    vectors++; if (bus.ra_data !== 64'd99) begin miscompares++; $display("FAIL hold_after got %0d want 99", bus.ra_data); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 5'd12, 5'd31, 5'd12, 1'b1, 5'd12, 64'd555);
    tick();
    vectors++; if (bus.ra_data !== 64'd555) begin miscompares++; $display("FAIL mid_pre got %0d want 555", bus.ra_data); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd12, 64'd777);
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++; if ({bus.ra_data, bus.rb_data, bus.rc_data} !== 192'd0) begin miscompares++; $display("FAIL mid_async got %h/%h/%h want 0", bus.ra_data, bus.rb_data, bus.rc_data); end
    vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_valid got %b want 0", bus.rd_valid); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.ra_data !== 64'd0) begin miscompares++; $display("FAIL mid_held got %0d want 0", bus.ra_data); end
    rst_n = 1'b1;
    drive(1'b1, 5'd12, 5'd31, 5'd3, 1'b0, 5'd0, 64'd0);
    tick();
    vectors++; if (bus.ra_data !== 64'd0) begin miscompares++; $display("FAIL mid_r12 got %0d want 0", bus.ra_data); end
    vectors++; if (bus.rb_data !== 64'd524288) begin miscompares++; $display("FAIL mid_r31 got %0d want 524288", bus.rb_data); end
    vectors++; if (bus.rc_data !== 64'd0) begin miscompares++; $display("FAIL mid_r3 got %0d want 0", bus.rc_data); end
  endtask

  task automatic test_mux();
    logic [63:0] want [3];
    want[0] = 64'd10; want[1] = 64'd20; want[2] = 64'd30;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'(i + 1), want[i]);
      tick();
    end
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 64'd0);
    tick();
    vectors++; if (bus.rd_valid !== 1'b1) begin miscompares++; $display("FAIL mux_valid got %b want 1", bus.rd_valid); end
    idle();
    for (int s = 0; s < 3; s++) begin
      ctrl = 2'(s);
      #1;
      vectors++; if (mux_out !== want[s]) begin miscompares++; $display("FAIL mux_ctrl%0d got %0d want %0d", s, mux_out, want[s]); end
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a, b, c, w;
      logic narrow;
      narrow = ($urandom_range(0, 1) == 1);
      a = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      b = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      c = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      w = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      drive(1'($urandom_range(0, 3) != 0), a, b, c, 1'($urandom_range(0, 1)), w,
            {$urandom, $urandom});
      tick();
      vectors++; if (bus.ra_data !== ma) begin miscompares++; $display("FAIL rand_ra cyc %0d got %h want %h", n, bus.ra_data, ma); end
      vectors++; if (bus.rb_data !== mb) begin miscompares++; $display("FAIL rand_rb cyc %0d got %h want %h", n, bus.rb_data, mb); end
      vectors++; if (bus.rc_data !== mc) begin miscompares++; $display("FAIL rand_rc cyc %0d got %h want %h", n, bus.rc_data, mc); end
      vectors++; if (bus.rd_valid !== mv) begin miscompares++; $display("FAIL rand_valid cyc %0d got %b want %b", n, bus.rd_valid, mv); end
    end
    // Sweep every register once so the whole file is compared.
    for (int r = 0; r < 32; r++) begin
      drive(1'b1, 5'(r), 5'(r), 5'(r), 1'b0, 5'd0, 64'd0);
      tick();
      vectors++; if (bus.ra_data !== mregs[r]) begin miscompares++; $display("FAIL sweep_r%0d got %h want %h", r, bus.ra_data, mregs[r]); end
    end
  endtask

  initial begin
    ctrl = 2'd0;
    idle();
    model_reset();
    test_reset();
    test_write_read();
    test_bypass();
    test_hold();
    test_reset_midstream();
    test_mux();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
